// File: rtl/mid_weight_streamer.sv
// Producer end of the midlayer weight interface: a host-loaded register file
// streamed out in index order over a valid/ready handshake.
module mid_weight_streamer #(
    parameter  int LENGHT_I = 32,
    parameter  int LENGHT_O = 8,
    parameter  int WIDTH_W  = 9,
    localparam int N        = LENGHT_I * LENGHT_O,
    localparam int ADDR_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [WIDTH_W-1:0] wr_data,
    output logic               wr_err,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WIDTH_W-1:0] w_o,
    output logic [ADDR_W-1:0]  w_idx,
    output logic               w_row_last,
    output logic               w_last
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int                COL_W    = (LENGHT_I > 1) ? $clog2(LENGHT_I) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LENGHT_I - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N);

    logic [WIDTH_W-1:0] r_mem [N];
    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic [COL_W-1:0]   r_col;
    logic [WIDTH_W-1:0] r_wo;
    logic               r_valid;
    logic               r_row_last;
    logic               r_last;
    logic               r_done;
    logic               r_wr_err;

    logic               w_busy;
    logic               w_addr_ok;
    logic               w_wr_commit;
    logic               w_start;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_idx_nxt;
    logic [COL_W-1:0]   w_col_nxt;
    logic [WIDTH_W-1:0] w_first;

    assign w_busy      = (r_state == S_STREAM);
    assign w_addr_ok   = ({1'b0, wr_addr} < N_EXT);
    assign w_wr_commit = wr_en && !w_busy && w_addr_ok;
    assign w_start     = (r_state == S_IDLE) && start && !abort;
    assign w_accept    = r_valid && w_ready;
    assign w_idx_nxt   = r_idx + ADDR_W'(1);
    assign w_col_nxt   = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
    // A write to entry 0 in the same cycle as start must reach the first beat.
    assign w_first     = (w_wr_commit && (wr_addr == '0)) ? wr_data : r_mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else if (w_wr_commit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr_err <= 1'b0;
        else        r_wr_err <= wr_en && (w_busy || !w_addr_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_col      <= '0;
            r_wo       <= '0;
            r_valid    <= 1'b0;
            r_row_last <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_STREAM;
                        r_valid    <= 1'b1;
                        r_idx      <= '0;
                        r_col      <= '0;
                        r_wo       <= w_first;
                        r_row_last <= (COL_LAST == '0);
                        r_last     <= (IDX_LAST == '0);
                    end
                end
                S_STREAM: begin
                    // Abort takes priority, even over acceptance of the final beat.
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_valid    <= 1'b0;
                        r_row_last <= 1'b0;
                        r_last     <= 1'b0;
                    end else if (w_accept) begin
                        if (r_last) begin
                            r_state    <= S_DONE;
                            r_valid    <= 1'b0;
                            r_row_last <= 1'b0;
                            r_last     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_col      <= w_col_nxt;
                            r_wo       <= r_mem[w_idx_nxt];
                            r_row_last <= (w_col_nxt == COL_LAST);
                            r_last     <= (w_idx_nxt == IDX_LAST);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_err     = r_wr_err;
    assign busy       = w_busy;
    assign done       = r_done;
    assign w_valid    = r_valid;
    assign w_o        = r_wo;
    assign w_idx      = r_idx;
    assign w_row_last = r_row_last;
    assign w_last     = r_last;

endmodule

// File: tb/tb_mid_weight_streamer.sv
// Directed bench for mid_weight_streamer: inputs driven and outputs sampled on
// the falling edge, expected weights held in a bench-side copy of the memory.
module tb_mid_weight_streamer;

    logic       clk, rst_n, wr_en, wr_err, start, abort, busy, done;
    logic       w_valid, w_ready, w_row_last, w_last;
    logic [7:0] wr_addr, w_idx;
    logic [8:0] wr_data, w_o;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_mem [256];

    int s_acc, s_seq_err, s_val_err, s_row_err, s_row_cnt, s_last_err, s_stall_err;
    int s_done_cnt, s_done_t, s_wrerr_cnt, s_last_c;
    logic s_timeout, s_first_valid, s_tail_valid, s_tail_busy;
    logic [8:0] s_val200;

    mid_weight_streamer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .start(start), .abort(abort), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_o(w_o), .w_idx(w_idx),
        .w_row_last(w_row_last), .w_last(w_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one stream and records what was observed; each test judges the record.
    task automatic stream(input logic [3:0] pat, input int abort_idx, input int wr_idx);
        int exp_idx, c;
        logic ended, rdy, prev_stall, wr_sent;
        logic [8:0] prev_o;
        logic [7:0] prev_idx;
        s_acc = 0; s_seq_err = 0; s_val_err = 0; s_row_err = 0; s_row_cnt = 0;
        s_last_err = 0; s_stall_err = 0; s_done_cnt = 0; s_done_t = -1;
        s_wrerr_cnt = 0; s_last_c = -1; s_timeout = 0; s_val200 = 9'h0;
        exp_idx = 0; c = 0; ended = 0; prev_stall = 0; wr_sent = 0;
        prev_o = 9'h0; prev_idx = 8'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_first_valid = w_valid;
        while (!ended && c < 3000) begin
            if (done) s_done_cnt++;
            if (wr_err) s_wrerr_cnt++;
            wr_en = 1'b0;
            abort = 1'b0;
            rdy = pat[c % 4];
            if (w_valid) begin
                if (w_idx !== exp_idx[7:0]) s_seq_err++;
                if (w_o !== exp_mem[exp_idx]) s_val_err++;
                if (w_row_last !== ((exp_idx % 32) == 31)) s_row_err++;
                if (w_last !== (exp_idx == 255)) s_last_err++;
                if (prev_stall && (w_o !== prev_o || w_idx !== prev_idx)) s_stall_err++;
                if (exp_idx == 200) s_val200 = w_o;
                if (exp_idx == wr_idx && !wr_sent) begin
                    wr_en = 1'b1; wr_addr = 8'd200; wr_data = 9'h1FF; wr_sent = 1'b1;
                end
                if (exp_idx == abort_idx) begin
                    abort = 1'b1;
                    ended = 1'b1;
                end else if (rdy) begin
                    s_acc++;
                    if (w_row_last) s_row_cnt++;
                    if (w_last) begin
                        ended = 1'b1;
                        s_last_c = c;
                    end
                    exp_idx++;
                end
                prev_stall = !rdy;
                prev_o = w_o;
                prev_idx = w_idx;
            end else begin
                s_seq_err++;
            end
            w_ready = rdy;
            c++;
            @(negedge clk);
        end
        if (!ended) s_timeout = 1'b1;
        w_ready = 1'b0; abort = 1'b0; wr_en = 1'b0;
        s_tail_valid = w_valid;
        s_tail_busy = busy;
        for (int t = 0; t < 3; t++) begin
            if (done) begin
                s_done_cnt++;
                if (s_done_t < 0) s_done_t = t;
            end
            if (wr_err) s_wrerr_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", w_valid); end
        checks++; if ({busy, done, wr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, wr_err}); end
        checks++; if ({w_o, w_idx, w_row_last, w_last} !== 19'h0) begin errors++; $display("FAIL reset_beat: got %h expected 0", {w_o, w_idx, w_row_last, w_last}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_stream();
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = 9'(i % 512);
            exp_mem[i] = 9'(i % 512);
            @(negedge clk);
        end
        wr_en = 1'b0;
        stream(4'b1111, -1, -1);
        checks++; if (s_first_valid !== 1'b1) begin errors++; $display("FAIL load_first_valid: got %0d expected 1", s_first_valid); end
        checks++; if (s_timeout !== 1'b0) begin errors++; $display("FAIL load_timeout: got %0d expected 0", s_timeout); end
        checks++; if (s_acc !== 256) begin errors++; $display("FAIL load_beats: got %0d expected 256", s_acc); end
        checks++; if (s_seq_err + s_val_err !== 0) begin errors++; $display("FAIL load_order_value: got %0d bad beats expected 0", s_seq_err + s_val_err); end
        checks++; if (s_row_err !== 0 || s_row_cnt !== 8) begin errors++; $display("FAIL load_row_last: got %0d errs %0d rows expected 0 errs 8 rows", s_row_err, s_row_cnt); end
        checks++; if (s_last_err !== 0) begin errors++; $display("FAIL load_last: got %0d errs expected 0", s_last_err); end
        checks++; if (s_last_c !== 255) begin errors++; $display("FAIL load_rate: got last at cycle %0d expected 255", s_last_c); end
        checks++; if (s_done_t !== 0 || s_done_cnt !== 1) begin errors++; $display("FAIL load_done: got t=%0d cnt=%0d expected t=0 cnt=1", s_done_t, s_done_cnt); end
        checks++; if (s_tail_busy !== 1'b0 || s_tail_valid !== 1'b0) begin errors++; $display("FAIL load_tail: got busy=%0d valid=%0d expected 0 0", s_tail_busy, s_tail_valid); end
        checks++; if (s_wrerr_cnt !== 0) begin errors++; $display("FAIL load_wr_err: got %0d expected 0", s_wrerr_cnt); end
    endtask

    task automatic test_backpressure();
        stream(4'b1001, -1, -1);
        checks++; if (s_acc !== 256) begin errors++; $display("FAIL bp_beats: got %0d expected 256", s_acc); end
        checks++; if (s_seq_err + s_val_err !== 0) begin errors++; $display("FAIL bp_order_value: got %0d bad beats expected 0", s_seq_err + s_val_err); end
        checks++; if (s_stall_err !== 0) begin errors++; $display("FAIL bp_stall_hold: got %0d expected 0", s_stall_err); end
        checks++; if (s_last_c !== 511) begin errors++; $display("FAIL bp_last_cycle: got %0d expected 511", s_last_c); end
        checks++; if (s_done_t !== 0 || s_done_cnt !== 1) begin errors++; $display("FAIL bp_done: got t=%0d cnt=%0d expected t=0 cnt=1", s_done_t, s_done_cnt); end
    endtask

    task automatic test_write_busy();
        stream(4'b1111, -1, 10);
        checks++; if (s_wrerr_cnt !== 1) begin errors++; $display("FAIL wb_err_pulse: got %0d expected 1", s_wrerr_cnt); end
        checks++; if (s_val200 !== 9'd200) begin errors++; $display("FAIL wb_old_value: got %0d expected 200", s_val200); end
        checks++; if (s_val_err !== 0) begin errors++; $display("FAIL wb_values: got %0d bad expected 0", s_val_err); end
        wr_en = 1'b1; wr_addr = 8'd200; wr_data = 9'h1FF;
        @(negedge clk);
        wr_en = 1'b0;
        exp_mem[200] = 9'h1FF;
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wb_idle_err: got %0d expected 0", wr_err); end
        stream(4'b1111, -1, -1);
        checks++; if (s_val200 !== 9'h1FF) begin errors++; $display("FAIL wb_new_value: got %h expected 1ff", s_val200); end
        checks++; if (s_val_err !== 0 || s_acc !== 256) begin errors++; $display("FAIL wb_second: got %0d bad %0d beats expected 0 256", s_val_err, s_acc); end
    endtask

    task automatic test_write_start();
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 9'h0AB; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        exp_mem[0] = 9'h0AB;
        checks++; if (w_valid !== 1'b1 || w_idx !== 8'd0) begin errors++; $display("FAIL ws_first: got valid=%0d idx=%0d expected 1 0", w_valid, w_idx); end
        checks++; if (w_o !== 9'h0AB) begin errors++; $display("FAIL ws_forward: got %h expected 0ab", w_o); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        stream(4'b1111, 100, -1);
        checks++; if (s_acc !== 100) begin errors++; $display("FAIL ab_beats: got %0d expected 100", s_acc); end
        checks++; if (s_tail_valid !== 1'b0 || s_tail_busy !== 1'b0) begin errors++; $display("FAIL ab_stop: got valid=%0d busy=%0d expected 0 0", s_tail_valid, s_tail_busy); end
        checks++; if (s_done_cnt !== 0) begin errors++; $display("FAIL ab_no_done: got %0d expected 0", s_done_cnt); end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || w_valid !== 1'b0) begin errors++; $display("FAIL ab_idle_block: got busy=%0d valid=%0d expected 0 0", busy, w_valid); end
        stream(4'b1111, -1, -1);
        checks++; if (s_acc !== 256 || s_seq_err !== 0 || s_val_err !== 0) begin errors++; $display("FAIL ab_restart: got %0d beats %0d bad expected 256 0", s_acc, s_seq_err + s_val_err); end
    endtask

    task automatic test_abort_last();
        stream(4'b1111, 255, -1);
        checks++; if (s_acc !== 255) begin errors++; $display("FAIL al_beats: got %0d expected 255", s_acc); end
        checks++; if (s_done_cnt !== 0) begin errors++; $display("FAIL al_no_done: got %0d expected 0", s_done_cnt); end
        checks++; if (s_tail_busy !== 1'b0 || s_tail_valid !== 1'b0) begin errors++; $display("FAIL al_idle: got busy=%0d valid=%0d expected 0 0", s_tail_busy, s_tail_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        start = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (w_idx !== 8'd50 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (w_idx !== 8'd50 || w_o !== 9'd50) begin errors++; $display("FAIL rm_reach: got idx=%0d w_o=%0d expected 50 50", w_idx, w_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({w_valid, busy, done, w_row_last, w_last} !== 5'b0) begin errors++; $display("FAIL rm_flags: got %b expected 00000", {w_valid, busy, done, w_row_last, w_last}); end
        checks++; if (w_o !== 9'h0 || w_idx !== 8'h0) begin errors++; $display("FAIL rm_beat: got w_o=%0d idx=%0d expected 0 0", w_o, w_idx); end
        w_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) exp_mem[i] = 9'h0;
        stream(4'b1111, -1, -1);
        checks++; if (s_acc !== 256 || s_val_err !== 0) begin errors++; $display("FAIL rm_zero_stream: got %0d beats %0d bad expected 256 0", s_acc, s_val_err); end
        checks++; if (s_done_cnt !== 1) begin errors++; $display("FAIL rm_done: got %0d expected 1", s_done_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'h0; wr_data = 9'h0;
        start = 1'b0; abort = 1'b0; w_ready = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 9'h0;
        test_reset();
        test_load_stream();
        test_backpressure();
        test_write_busy();
        test_write_start();
        test_abort();
        test_abort_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mid_weight_streamer.md
Name: mid_weight_streamer

Overview:
- Producer end of the midlayer weight interface.
- Holds the full LENGHT_I*LENGHT_O weight set in a local register file, loaded by a host write port.
- On start, streams the weights one per accepted beat, in index order 0..N-1, to the layer's WIDTH_W-bit weight input using a valid/ready handshake.
- Index k*LENGHT_I+m is the weight for output neuron k, input m; row and stream boundaries are flagged.

Parameters:
- LENGHT_I, 32, inputs per neuron (row length).
- LENGHT_O, 8, output neurons (row count).
- WIDTH_W, 9, weight width in bits.
- N (localparam), LENGHT_I*LENGHT_O, total weights (256 by default).
- ADDR_W (localparam), $clog2(N), index width (8 by default).

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  host write strobe.
- wr_addr  input  ADDR_W  host write index.
- wr_data  input  WIDTH_W  host write weight.
- wr_err  output  1  1-cycle pulse: a write was dropped.
- start  input  1  begin streaming; sampled in IDLE only.
- abort  input  1  cancel the stream.
- busy  output  1  high in STREAM.
- done  output  1  1-cycle pulse after the last beat is accepted.
- w_valid  output  1  beat valid.
- w_ready  input  1  consumer accepts the beat.
- w_o  output  WIDTH_W  weight value.
- w_idx  output  ADDR_W  index of w_o.
- w_row_last  output  1  w_idx%LENGHT_I==LENGHT_I-1.
- w_last  output  1  w_idx==N-1.

Behaviour:
- Reset (async assert, sync-safe deassert)
  - All outputs 0; FSM to IDLE; index to 0.
  - All register-file entries cleared to 0.
  - Reset mid-stream terminates immediately; no done.
- Register file
  - N x WIDTH_W, written on wr_en when not busy: mem[wr_addr] <= wr_data.
  - wr_addr >= N (only possible for non-power-of-2 N): write dropped, wr_err pulses.
  - wr_en while busy: write dropped, wr_err pulses the next cycle. Contents are therefore stable during a stream.
- FSM states: IDLE, STREAM, DONE.
  - IDLE: start=1 -> STREAM.
    - Next cycle: w_valid=1, w_idx=0, w_o=mem[0].
    - Latency start -> first valid beat is 1 cycle.
  - STREAM: all beat outputs are registered.
    - While w_valid && !w_ready: w_o, w_idx, w_row_last and w_last hold stable.
    - On w_valid && w_ready with !w_last: next cycle presents idx+1. Back-to-back acceptance gives 1 beat/cycle.
    - On w_valid && w_ready with w_last: go to DONE; w_valid drops next cycle.
  - DONE: done=1 for exactly one cycle, then IDLE. A start seen in DONE is ignored.
- Start handling
  - start in STREAM or DONE is ignored; no error.
  - start held continuously restarts on the cycle after returning to IDLE.
- Abort
  - abort=1 in STREAM -> IDLE next cycle; w_valid=0; no done pulse.
  - Abort wins over a simultaneous acceptance of the last beat.
  - abort in IDLE: no effect, and start is not taken that cycle.
- Simultaneous wr_en and start in IDLE
  - The write commits first.
  - The stream reads the updated value if wr_addr==0 (mem[0] read the cycle after).
- Beat count per completed stream is exactly N, with w_row_last asserted on LENGHT_O beats.

Test Plan:
- Reset load and stream
  - Stimulus: after reset write mem[i]=i%512 for i=0..255, pulse start, hold w_ready=1.
  - Response: 256 consecutive beats, w_o=w_idx; w_row_last at idx 31,63,...,255; w_last at 255; done 1 cycle after acceptance of 255; busy low after.
- Backpressure
  - Stimulus: w_ready toggles 1,0,0,1 repeating.
  - Response: w_o/w_idx stable during stalls; each index appears accepted exactly once; done after the 256th acceptance.
- Write while busy
  - Stimulus: wr_en at idx 10 with wr_addr=200, wr_data=0x1FF.
  - Response: wr_err pulse; beat 200 carries the old value; after done, the same write succeeds and a second stream shows 0x1FF at idx 200.
- Abort
  - Stimulus: abort at idx 100.
  - Response: w_valid=0 next cycle; no done; a new start restarts from idx 0.
- Abort on last
  - Stimulus: abort together with acceptance of idx 255.
  - Response: no done pulse; FSM returns to IDLE.
- Reset mid-stream
  - Stimulus: rst_n low at idx 50.
  - Response: outputs 0 immediately (asynchronously); after release, a stream yields all-zero weights.
